// File: rtl/nzcv_flag_unit_pkg.sv
// Shared constants for the NZCV status register: condition codes, the
// default flag field position and the offsets of N/Z/C/V within that field.
package nzcv_flag_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int DEFAULT_FLAG_LSB = 28;

  localparam int FLAG_N_OFF = 3;
  localparam int FLAG_Z_OFF = 2;
  localparam int FLAG_C_OFF = 1;
  localparam int FLAG_V_OFF = 0;

endpackage

// File: rtl/nzcv_flag_unit_cond_eval.sv
// Combinational LEGv8 condition evaluator; shared by branch and
// conditional-select logic.
module cond_eval
  import nzcv_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       pass
);

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      // AL and NV both always pass
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// NZCV status register with software write, flag-only update and a
// shadow stack for exception entry/return, plus B.cond evaluation.
module nzcv_flag_unit
  import nzcv_flag_unit_pkg::*;
#(
  parameter int SREG_W      = 32,
  parameter int FLAG_LSB    = DEFAULT_FLAG_LSB,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               set_flags,
  input  logic                               negative,
  input  logic                               zero,
  input  logic                               carry,
  input  logic                               overflow,
  input  logic                               wr_en,
  input  logic [SREG_W-1:0]                  wr_data,
  input  logic                               push,
  input  logic                               pop,
  input  logic [3:0]                         cond,
  output logic [SREG_W-1:0]                  sreg,
  output logic                               cond_pass,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty,
  output logic                               stack_err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;
  logic [SREG_W-1:0] stack_q [STACK_DEPTH];

  logic              is_empty, is_full;
  logic              do_push, do_pop, do_xchg, misuse;
  logic [IW-1:0]     top_idx, stk_widx;
  logic              stk_we;

  always_comb begin
    is_empty = (depth_q == '0);
    is_full  = (depth_q == DEPTH_MAX);
    do_xchg  = push & pop & ~is_empty;
    do_push  = push & ~pop & ~is_full;
    do_pop   = pop & ~push & ~is_empty;
    misuse   = (push & pop & is_empty) | (push & ~pop & is_full) |
               (pop & ~push & is_empty);
    top_idx  = IW'(depth_q - DW'(1));
    stk_we   = do_push | do_xchg;
    // an exchange overwrites the top entry in place; a push fills the next slot
    stk_widx = do_xchg ? top_idx : IW'(depth_q);
  end

  always_comb begin
    sreg_d = sreg_q;
    if (do_pop || do_xchg) begin
      sreg_d = stack_q[top_idx];
    end else if (wr_en) begin
      sreg_d = wr_data;
    end else if (set_flags) begin
      sreg_d[FLAG_LSB+FLAG_N_OFF] = negative;
      sreg_d[FLAG_LSB+FLAG_Z_OFF] = zero;
      sreg_d[FLAG_LSB+FLAG_C_OFF] = carry;
      sreg_d[FLAG_LSB+FLAG_V_OFF] = overflow;
    end

    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end

    err_d = err_q | misuse;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // stack contents are don't-care after reset, so they carry no reset
  always_ff @(posedge clk) begin
    if (stk_we) begin
      stack_q[stk_widx] <= sreg_q;
    end
  end

  cond_eval u_cond_eval (
    .cond (cond),
    .n    (sreg_q[FLAG_LSB+FLAG_N_OFF]),
    .z    (sreg_q[FLAG_LSB+FLAG_Z_OFF]),
    .c    (sreg_q[FLAG_LSB+FLAG_C_OFF]),
    .v    (sreg_q[FLAG_LSB+FLAG_V_OFF]),
    .pass (cond_pass)
  );

  assign sreg      = sreg_q;
  assign depth     = depth_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign stack_err = err_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Scoreboard bench for nzcv_flag_unit: a behavioural model queues the
// expected post-edge state per request, compared one cycle later.
module tb_nzcv_flag_unit;

  localparam int SREG_W = 32;
  localparam int DEPTH  = 4;
  localparam int DW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              set_flags = 1'b0;
  logic              negative = 1'b0, zero = 1'b0, carry = 1'b0, overflow = 1'b0;
  logic              wr_en = 1'b0;
  logic [SREG_W-1:0] wr_data = '0;
  logic              push = 1'b0, pop = 1'b0;
  logic [3:0]        cond = 4'd0;
  logic [SREG_W-1:0] sreg;
  logic              cond_pass;
  logic [DW-1:0]     depth;
  logic              full, empty, stack_err;

  nzcv_flag_unit #(.SREG_W(SREG_W), .FLAG_LSB(28), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .set_flags(set_flags),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .wr_en(wr_en), .wr_data(wr_data), .push(push), .pop(pop), .cond(cond),
    .sreg(sreg), .cond_pass(cond_pass), .depth(depth), .full(full),
    .empty(empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sreg;
    int          depth;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_sreg;
  logic [31:0] m_stk[$];
  logic        m_err;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (c[0] ? !base : base);
  endfunction

  task automatic model_reset();
    m_sreg = '0;
    m_err  = 1'b0;
    m_stk.delete();
  endtask

  // drive one request, queue the expected result, compare after the edge
  task automatic cycle(input logic sf, input logic [3:0] flg, input logic we,
                       input logic [31:0] wd, input logic pu, input logic po);
    exp_t e, got;
    logic taken;
    logic [31:0] nxt, tmp;
    set_flags = sf; {negative, zero, carry, overflow} = flg;
    wr_en = we; wr_data = wd; push = pu; pop = po;
    taken = 1'b0;
    nxt = m_sreg;
    if (pu && po) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin tmp = m_stk[$]; m_stk[$] = m_sreg; nxt = tmp; taken = 1'b1; end
    end else if (pu) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_sreg);
    end else if (po) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin nxt = m_stk.pop_back(); taken = 1'b1; end
    end
    if (!taken) begin
      if (we) nxt = wd;
      else if (sf) nxt = {flg, m_sreg[27:0]};
    end
    m_sreg = nxt;
    e.sreg = m_sreg; e.depth = m_stk.size(); e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sreg", 64'(sreg), 64'(got.sreg));
    check("depth", 64'(depth), 64'(got.depth));
    check("stack_err", 64'(stack_err), 64'(got.err));
    check("full", 64'(full), 64'(got.depth == DEPTH));
    check("empty", 64'(empty), 64'(got.depth == 0));
    set_flags = 1'b0; wr_en = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_sreg", 64'(sreg), 64'h0);
    check("rst_depth", 64'(depth), 64'h0);
    check("rst_empty", 64'(empty), 64'h1);
    check("rst_full", 64'(full), 64'h0);
    check("rst_err", 64'(stack_err), 64'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // set_flags and condition read-back
    cycle(1'b1, 4'b1010, 1'b0, '0, 1'b0, 1'b0);
    check("setflags_sreg", 64'(sreg), 64'hA000_0000);
    cond = 4'd2; #1; check("cond_HS", 64'(cond_pass), 64'h1);
    cond = 4'd3; #1; check("cond_LO", 64'(cond_pass), 64'h0);

    // write beats flags, then flags touch only the top nibble
    cycle(1'b1, 4'b1111, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check("wr_wins", 64'(sreg), 64'h1234_5678);
    cycle(1'b1, 4'b0000, 1'b0, '0, 1'b0, 1'b0);
    check("flags_only", 64'(sreg), 64'h0234_5678);

    // push / pop round trip
    cycle(1'b0, 4'b0, 1'b1, 32'h5000_0001, 1'b0, 1'b0);
    cycle(1'b0, 4'b0, 1'b0, '0, 1'b1, 1'b0);
    check("push_depth", 64'(depth), 64'h1);
    cycle(1'b0, 4'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'b0, 1'b0, '0, 1'b0, 1'b1);
    check("pop_sreg", 64'(sreg), 64'h5000_0001);
    check("pop_empty", 64'(empty), 64'h1);

    // overflow: push with a same-cycle write, then drain in LIFO order
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0, 1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
      if (i == 3) check("full_at_4", 64'(full), 64'h1);
    end
    check("ovf_depth", 64'(depth), 64'h4);
    check("ovf_err", 64'(stack_err), 64'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0, 1'b0, '0, 1'b0, 1'b1);
    check("lifo_last", 64'(sreg), 64'h5000_0001);

    // underflow with set_flags
    do_reset();
    cycle(1'b1, 4'b0100, 1'b0, '0, 1'b0, 1'b1);
    check("unf_sreg", 64'(sreg), 64'h4000_0000);
    check("unf_err", 64'(stack_err), 64'h1);

    // exchange
    do_reset();
    cycle(1'b0, 4'b0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    cycle(1'b0, 4'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 4'b0, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    cycle(1'b0, 4'b0, 1'b0, '0, 1'b1, 1'b1);
    check("xchg_sreg", 64'(sreg), 64'hAAAA_0001);
    check("xchg_depth", 64'(depth), 64'h1);
    cycle(1'b0, 4'b0, 1'b0, '0, 1'b0, 1'b1);
    check("xchg_top", 64'(sreg), 64'hBBBB_0002);
    // push+pop on empty is ignored but the write still lands
    cycle(1'b0, 4'b0, 1'b1, 32'hCCCC_0003, 1'b1, 1'b1);
    check("xchg_empty_err", 64'(stack_err), 64'h1);

    // asynchronous reset mid-cycle with depth 3 and a sticky error
    do_reset();
    cycle(1'b0, 4'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0, 1'b1, 32'h7000 + 32'(i), 1'b1, 1'b0);
    check("pre_rst_depth", 64'(depth), 64'h3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_sreg", 64'(sreg), 64'h0);
    check("arst_depth", 64'(depth), 64'h0);
    check("arst_err", 64'(stack_err), 64'h0);
    check("arst_empty", 64'(empty), 64'h1);
    check("arst_full", 64'(full), 64'h0);
    #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // all conditions against all flag combinations
    for (int f = 0; f < 16; f++) begin
      cycle(1'b1, 4'(f), 1'b0, '0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        check($sformatf("cond%0d_f%0h", c, f), 64'(cond_pass), 64'(cond_ref(4'(c), 4'(f))));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nzcv_flag_unit.md
# nzcv_flag_unit

Parametrised NZCV status register for the execute stage, the successor to the fixed 32-bit flag register. Flags update only when the instruction sets flags (ADDS/SUBS/ANDS…), software can write the full register, and a shadow stack saves and restores the register on exception entry and return. The unit also evaluates the 4-bit LEGv8 condition field for B.cond against the registered flags.

## Interface
- SREG_W, 32, register width; must be ≥ FLAG_LSB+4
- FLAG_LSB, 28, bit position of V; flags are N=[FLAG_LSB+3], Z=[FLAG_LSB+2], C=[FLAG_LSB+1], V=[FLAG_LSB]
- STACK_DEPTH, 4, shadow-stack entries, ≥1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- set_flags  in  1  load N/Z/C/V from ALU inputs this cycle
- negative, zero, carry, overflow  in  1 each  ALU flag outputs
- wr_en  in  1  software write of the full register
- wr_data  in  SREG_W  software write value
- push  in  1  save the current sreg to the shadow stack (exception entry)
- pop  in  1  restore sreg from the top of the stack (exception return)
- cond  in  4  condition code for evaluation
- sreg  out  SREG_W  registered status register
- cond_pass  out  1  condition result, combinational from sreg and cond
- depth  out  $clog2(STACK_DEPTH+1)  entries in use
- full, empty  out  1 each  stack status
- stack_err  out  1  sticky misuse flag

## Operation
- Next-sreg priority per cycle:
  - a valid pop takes sreg from the top entry;
  - otherwise, wr_en loads wr_data;
  - otherwise, set_flags replaces only the four flag bits;
  - otherwise, sreg holds.
- Non-flag bits change only on a pop or wr_en.
- A push stores the pre-edge sreg value. A flag or software update in the same cycle still applies to sreg.
- push and pop together, stack not empty: exchange. The top entry gets the current sreg, sreg gets the old top, and depth is unchanged.
- push and pop together, stack empty: both are ignored and stack_err sets. wr_en or set_flags still applies.
- push when full, push-only: the push is ignored, stack_err sets, depth stays at STACK_DEPTH, and other updates still apply.
- pop when empty, pop-only: the pop is ignored, stack_err sets, and wr_en or set_flags applies.
- stack_err is sticky until reset.
- cond_pass, from the registered flags:
  - 0 EQ Z; 1 NE !Z
  - 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL and 15 NV are both 1
- full = (depth==STACK_DEPTH). empty = (depth==0).

## Timing
- All state updates on the rising edge of clk. New sreg, depth, full, empty and stack_err are visible the cycle after the request: one-cycle latency.
- cond_pass has zero-cycle latency from cond. It reflects flags written at the previous edge; there is no same-cycle bypass. The decode stage must not evaluate in the same cycle as a flag-setting instruction.
- Reset (asynchronous, immediate, also mid-operation): sreg=0, depth=0, empty=1, full=0, stack_err=0. Stack contents are not cleared and are don't-care.
- Requests are single-cycle levels; there is no handshake. The caller honours full/empty or accepts stack_err.

## Structure
- Shared constants header:
  - condition-code localparams COND_EQ…COND_NV;
  - default FLAG_LSB;
  - flag index offsets N/Z/C/V.
- Sub-module cond_eval: purely combinational; inputs cond and the 4 flags, output pass. Reused later by conditional-select logic.
- Stack: register array indexed by depth-1. No separate pointer is kept.

## Test plan
- **Reset and set_flags:** reset, then set_flags=1, N=1, Z=0, C=1, V=0 → sreg=32'hA000_0000; with cond=2 (HS) cond_pass=1, with cond=3 (LO) cond_pass=0.
- **Write vs flags priority:** wr_en=1, wr_data=32'h1234_5678 with set_flags=1 and flags=1111 in the same cycle → sreg=32'h1234_5678 (write wins). Next cycle set_flags with flags=0000 → sreg=32'h0234_5678.
- **Push then pop:** from sreg=32'h5000_0001, push → depth=1; wr_en 0 → sreg=0; pop → sreg=32'h5000_0001, depth=0, empty=1.
- **Overflow:** with STACK_DEPTH=4, five pushes → full=1 after the 4th; 5th leaves depth=4 and stack_err=1; four pops return values in LIFO order.
- **Underflow and exchange:**
  - pop when empty with set_flags, Z=1 → sreg=32'h4000_0000, stack_err=1;
  - after a reset, push A, then set sreg=B, then push+pop together → sreg=A, top=B, depth=1.
- **Asynchronous reset:** assert reset mid-cycle with depth=3 → sreg=0, depth=0, stack_err=0 before the next edge. Sweep all 16 cond codes against all 16 flag combinations and compare with a reference model.
